clk_div_prog: RTL and testbench



---
 rtl/clk_div_pkg.sv | 17 +
 rtl/clk_div_chan.sv | 79 +++++++
 rtl/clk_div_prog.sv | 66 ++++++
 tb/tb_clk_div_prog.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants and helpers for the programmable clock divider.
//   DIV_MIN          smallest divisor a channel ever runs with
//   CNT_W_DEF        default counter/divisor width
//   DIV_DEFAULT_DEF  default reset divisor (1 Hz from 100 MHz)
//   div_clamp()      maps divisors 0 and 1 onto DIV_MIN (widths up to 32 bits)
package clk_div_pkg;

    localparam int DIV_MIN         = 2;
    localparam int CNT_W_DEF       = 27;
    localparam int DIV_DEFAULT_DEF = 100000000;

    // Divisors below DIV_MIN would make cnt==div-1 underflow; run them as DIV_MIN.
    function automatic logic [31:0] div_clamp(input logic [31:0] d);
        return (d < 32'(DIV_MIN)) ? 32'(DIV_MIN) : d;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel.
//   clk_in    system clock
//   rst       synchronous reset, active-high
//   en        run enable; 0 holds cnt and clk_out
//   align     realign pulse: cnt/clk_out cleared, tick suppressed, pending applied
//   wr        divisor write strobe for this channel
//   wr_div    raw divisor (clamped here)
//   tick      one-cycle pulse at the end of every period
//   clk_out   square wave, low for div/2 counts then high
//   pending   a written divisor waits for the next wrap
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DIV_DEFAULT = DIV_DEFAULT_DEF
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             align,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    output logic             tick,
    output logic             clk_out,
    output logic             pending
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] div_pend;
    logic [CNT_W-1:0] cnt_next;
    logic             wrap;

    // div is never below DIV_MIN, so div-1 cannot underflow.
    always_comb begin
        wrap     = en && (cnt == div - 1'b1);
        cnt_next = cnt;
        if (wrap)
            cnt_next = '0;
        else if (en)
            cnt_next = cnt + 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt      <= '0;
            div      <= CNT_W'(DIV_DEFAULT);
            div_pend <= CNT_W'(DIV_DEFAULT);
            pending  <= 1'b0;
            tick     <= 1'b0;
            clk_out  <= 1'b0;
        end else if (align) begin
            // Write strobe is dropped on an align edge.
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            if (pending) begin
                div     <= div_pend;
                pending <= 1'b0;
            end
        end else begin
            cnt  <= cnt_next;
            tick <= wrap;
            // On wrap cnt_next is 0 and div/2 >= 1, so the fall lines up with tick.
            if (en)
                clk_out <= (cnt_next >= (div >> 1));
            if (wrap && pending) begin
                div     <= div_pend;
                pending <= 1'b0;
            end
            // Placed after the apply so a same-edge write stays pending.
            if (wr) begin
                div_pend <= CNT_W'(div_clamp(32'(wr_div)));
                pending  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable multi-channel clock divider.
//   clk_in       system clock
//   rst          synchronous reset, active-high
//   en           per-channel run enable (0 = pause)
//   cfg_wr       one-cycle divisor write strobe
//   cfg_ch       target channel; values >= NUM_CH are ignored
//   cfg_div      new divisor (0 and 1 run as 2)
//   tick         per-channel one-cycle period pulse
//   clk_out      per-channel square wave
//   cfg_pending  per-channel written-but-unapplied flag
//   align        only with CLK_DIV_PHASE_ALIGN_EN defined: restarts all channels together
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DIV_DEFAULT = DIV_DEFAULT_DEF,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
`ifdef CLK_DIV_PHASE_ALIGN_EN
    input  logic              align,
`endif
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] cfg_pending
);

    logic align_i;
`ifdef CLK_DIV_PHASE_ALIGN_EN
    assign align_i = align;
`else
    assign align_i = 1'b0;
`endif

    logic [NUM_CH-1:0] wr_sel;

    // Out-of-range cfg_ch matches no index, so such writes fall on the floor.
    genvar i;
    generate
        for (i = 0; i < NUM_CH; i++) begin : g_ch
            assign wr_sel[i] = cfg_wr && (cfg_ch == CH_W'(i));

            clk_div_chan #(
                .CNT_W       (CNT_W),
                .DIV_DEFAULT (DIV_DEFAULT)
            ) u_chan (
                .clk_in  (clk_in),
                .rst     (rst),
                .en      (en[i]),
                .align   (align_i),
                .wr      (wr_sel[i]),
                .wr_div  (cfg_div),
                .tick    (tick[i]),
                .clk_out (clk_out[i]),
                .pending (cfg_pending[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clk_div_prog.sv
module tb_clk_div_prog;

    localparam int NUM_CH      = 2;
    localparam int CNT_W       = 8;
    localparam int DIV_DEFAULT = 4;

    logic              clk_in = 1'b0;
    logic              rst    = 1'b1;
    logic [1:0]        en     = 2'b00;
    logic              cfg_wr = 1'b0;
    logic [0:0]        cfg_ch = 1'b0;
    logic [CNT_W-1:0]  cfg_div = '0;
`ifdef CLK_DIV_PHASE_ALIGN_EN
    logic              align  = 1'b0;
`endif
    logic [1:0]        tick;
    logic [1:0]        clk_out;
    logic [1:0]        cfg_pending;

    int checks   = 0;
    int failures = 0;

    clk_div_prog #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DIV_DEFAULT (DIV_DEFAULT)
    ) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .en          (en),
`ifdef CLK_DIV_PHASE_ALIGN_EN
        .align       (align),
`endif
        .cfg_wr      (cfg_wr),
        .cfg_ch      (cfg_ch),
        .cfg_div     (cfg_div),
        .tick        (tick),
        .clk_out     (clk_out),
        .cfg_pending (cfg_pending)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
        end
    endtask

    // Reference model: elapsed enabled cycles within the current period.
    int m_el[NUM_CH];
    int m_per[NUM_CH];
    int m_sh[NUM_CH];
    bit m_pend[NUM_CH];
    bit m_tick[NUM_CH];
    bit m_clk[NUM_CH];
    bit m_live = 1'b0;

    always @(posedge clk_in) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (rst) begin
                m_el[c] = 0; m_per[c] = DIV_DEFAULT; m_pend[c] = 0;
                m_tick[c] = 0; m_clk[c] = 0; m_live = 1'b1;
            end
`ifdef CLK_DIV_PHASE_ALIGN_EN
            else if (align) begin
                m_el[c] = 0; m_tick[c] = 0; m_clk[c] = 0;
                if (m_pend[c]) begin m_per[c] = m_sh[c]; m_pend[c] = 0; end
            end
`endif
            else begin
                m_tick[c] = 0;
                if (en[c]) begin
                    m_el[c]++;
                    if (m_el[c] == m_per[c]) begin
                        m_tick[c] = 1; m_el[c] = 0;
                        if (m_pend[c]) begin m_per[c] = m_sh[c]; m_pend[c] = 0; end
                    end
                    m_clk[c] = (m_el[c] >= m_per[c] / 2);
                end
                if (cfg_wr && int'(cfg_ch) == c) begin
                    m_sh[c]   = (int'(cfg_div) < 2) ? 2 : int'(cfg_div);
                    m_pend[c] = 1;
                end
            end
        end
    end

    always @(negedge clk_in) begin
        if (m_live) begin
            logic [1:0] et, ec, ep;
            for (int c = 0; c < NUM_CH; c++) begin
                et[c] = m_tick[c]; ec[c] = m_clk[c]; ep[c] = m_pend[c];
            end
            chk("model_tick", 32'(tick), 32'(et));
            chk("model_clk_out", 32'(clk_out), 32'(ec));
            chk("model_pending", 32'(cfg_pending), 32'(ep));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic wait_tick(input int ch, output int n);
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (!tick[ch] && n < 64);
        if (!tick[ch]) chk("tick_timeout", 32'(n), 32'(0));
    endtask

    task automatic write(input int ch, input int d);
        cfg_wr  = 1'b1;
        cfg_ch  = 1'(ch);
        cfg_div = CNT_W'(d);
    endtask

    initial begin
        int n;
        // 1: reset then default period 4
        rst = 1'b1; en = 2'b11;
        step(3);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_clk_out", 32'(clk_out), 0);
        chk("rst_pending", 32'(cfg_pending), 0);
        rst = 1'b0;
        step(1); chk("t1_clk_c1", 32'(clk_out[0]), 0);
        step(1); chk("t1_clk_c2", 32'(clk_out[0]), 1);
        step(1); chk("t1_clk_c3", 32'(clk_out[0]), 1);
        chk("t1_no_tick_e3", 32'(tick), 0);
        step(1); chk("t1_first_tick", 32'(tick), 32'b11);
        chk("t1_clk_c0", 32'(clk_out[0]), 0);

        // 2: ch1 divisor 5 written at cnt=1
        step(1);
        write(1, 5);
        step(1); cfg_wr = 1'b0;
        chk("t2_pending", 32'(cfg_pending), 32'b10);
        step(1); chk("t2_pending_hold", 32'(cfg_pending[1]), 1);
        step(1); chk("t2_wrap_tick", 32'(tick[1]), 1);
        chk("t2_applied", 32'(cfg_pending[1]), 0);
        step(1); chk("t2_p1", 32'(clk_out[1]), 0);
        step(1); chk("t2_p2", 32'(clk_out[1]), 1);
        step(1); chk("t2_p3", 32'(clk_out[1]), 1);
        step(1); chk("t2_p4", 32'(clk_out[1]), 1);
        chk("t2_p4_notick", 32'(tick[1]), 0);
        step(1); chk("t2_p0_tick", 32'(tick[1]), 1);
        chk("t2_p0", 32'(clk_out[1]), 0);

        // 3: divisors 0 and 1 run as 2
        write(1, 0);
        step(1); cfg_wr = 1'b0;
        wait_tick(1, n);
        wait_tick(1, n); chk("t3_div0_period", 32'(n), 2);
        chk("t3_clk_lo", 32'(clk_out[1]), 0);
        write(1, 1);
        step(1); cfg_wr = 1'b0;
        chk("t3_clk_hi", 32'(clk_out[1]), 1);
        wait_tick(1, n);
        wait_tick(1, n); chk("t3_div1_period", 32'(n), 2);

        // 4: pause ch0 three cycles at cnt=2
        wait_tick(0, n);
        step(2); chk("t4_clk_before", 32'(clk_out[0]), 1);
        en = 2'b10;
        step(3);
        chk("t4_clk_held", 32'(clk_out[0]), 1);
        chk("t4_no_tick", 32'(tick[0]), 0);
        en = 2'b11;
        wait_tick(0, n); chk("t4_stretched", 32'(2 + 3 + n), 7);

        // 5: write 6 on the wrap edge with 3 already pending
        wait_tick(0, n);
        write(0, 3);
        step(1); cfg_wr = 1'b0;
        step(2);
        write(0, 6);
        step(1); cfg_wr = 1'b0;
        chk("t5_wrap_tick", 32'(tick[0]), 1);
        chk("t5_still_pending", 32'(cfg_pending[0]), 1);
        wait_tick(0, n); chk("t5_period3", 32'(n), 3);
        chk("t5_applied", 32'(cfg_pending[0]), 0);
        wait_tick(0, n); chk("t5_period6", 32'(n), 6);

        // 6: reset mid-period with a pending write
        write(0, 7);
        step(1); cfg_wr = 1'b0;
        step(1); chk("t6_pending", 32'(cfg_pending[0]), 1);
        rst = 1'b1;
        step(1);
        chk("t6_tick", 32'(tick), 0);
        chk("t6_clk_out", 32'(clk_out), 0);
        chk("t6_pending_clr", 32'(cfg_pending), 0);
        rst = 1'b0;
        wait_tick(0, n); chk("t6_period", 32'(n), 4);
        chk("t6_both", 32'(tick), 32'b11);

`ifdef CLK_DIV_PHASE_ALIGN_EN
        en = 2'b10; step(1); en = 2'b11; step(2);
        align = 1'b1;
        step(1); align = 1'b0;
        chk("al_tick", 32'(tick), 0);
        chk("al_clk", 32'(clk_out), 0);
        wait_tick(0, n); chk("al_period", 32'(n), 4);
        chk("al_both", 32'(tick), 32'b11);
`endif

        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
